dffrs_shift_bank: RTL and testbench

//   Parametrised successor to the single-bit set/reset flop: a WIDTH-bit register bank.
//   - Async active-low reset (RN) and async active-low set (SN).
//   - Synchronous mode control: hold, parallel load, shift left, shift right.
//   - Registered serial-out flag and true/complement outputs.
//   - Sits wherever datapath capture, serialisation or deserialisation is needed.

---
 rtl/dffrs_pkg.sv | 11 +
 rtl/dffrs_bit.sv | 26 ++
 rtl/dffrs_shift_bank.sv | 85 ++++++++
 tb/tb_dffrs_shift_bank.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/dffrs_pkg.sv
// rtl/dffrs_pkg.sv - mode encodings and default width for the dffrs shift bank
package dffrs_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_LOAD = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_SHR  = 2'b11;

endpackage

// File: rtl/dffrs_bit.sv
// rtl/dffrs_bit.sv - single flop with async active-low reset (priority) and set
module dffrs_bit #(
  parameter logic SET_VAL = 1'b1
) (
  input  logic ck,
  input  logic rn,
  input  logic sn,
  input  logic d,
  output logic q,
  output logic qn
);

  // Reset outranks set when both are low.
  always_ff @(posedge ck or negedge rn or negedge sn) begin
    if (!rn) begin
      q <= 1'b0;
    end else if (!sn) begin
      q <= SET_VAL;
    end else begin
      q <= d;
    end
  end

  assign qn = ~q;

endmodule

// File: rtl/dffrs_shift_bank.sv
// rtl/dffrs_shift_bank.sv - WIDTH-bit set/reset shift register bank
// Optional registered even parity output PAR when DFFRS_PARITY_EN is defined.
module dffrs_shift_bank
  import dffrs_pkg::*;
#(
  parameter int               WIDTH     = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] SET_VALUE = {WIDTH{1'b1}}
) (
  input  logic             CK,
  input  logic             RN,
  input  logic             SN,
  input  logic [1:0]       MODE,
  input  logic [WIDTH-1:0] D,
  input  logic             SI,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] QN,
`ifdef DFFRS_PARITY_EN
  output logic             SO,
  output logic             PAR
`else
  output logic             SO
`endif
);

  logic [WIDTH-1:0] q_next;
  logic             so_next;
  logic             unused_so_n;

  // Unknown MODE falls through to default and holds the register.
  always_comb begin
    q_next  = Q;
    so_next = SO;
    case (MODE)
      MODE_LOAD: q_next = D;
      MODE_SHL: begin
        q_next  = {Q[WIDTH-2:0], SI};
        so_next = Q[WIDTH-1];
      end
      MODE_SHR: begin
        q_next  = {SI, Q[WIDTH-1:1]};
        so_next = Q[0];
      end
      default: ;
    endcase
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    dffrs_bit #(.SET_VAL(SET_VALUE[i])) u_bit (
      .ck (CK),
      .rn (RN),
      .sn (SN),
      .d  (q_next[i]),
      .q  (Q[i]),
      .qn (QN[i])
    );
  end

  // Serial-out flag clears on set as well as reset.
  dffrs_bit #(.SET_VAL(1'b0)) u_so (
    .ck (CK),
    .rn (RN),
    .sn (SN),
    .d  (so_next),
    .q  (SO),
    .qn (unused_so_n)
  );

`ifdef DFFRS_PARITY_EN
  logic unused_par_n;

  // Parity is taken from the next state so it lands on the same edge as Q.
  dffrs_bit #(.SET_VAL(^SET_VALUE)) u_par (
    .ck (CK),
    .rn (RN),
    .sn (SN),
    .d  (^q_next),
    .q  (PAR),
    .qn (unused_par_n)
  );
`endif

  a_mode_known : assert property (@(posedge CK) disable iff (!RN || !SN) !$isunknown(MODE))
    else $error("MODE is X/Z");

endmodule

// File: tb/tb_dffrs_shift_bank.sv
// tb/tb_dffrs_shift_bank.sv - randomized self-checking bench with behavioural model
module tb_dffrs_shift_bank;
  import dffrs_pkg::*;

  localparam int W = 8;
  localparam logic [W-1:0] SETV = 8'hFF;

  logic         CK   = 1'b0;
  logic         RN   = 1'b1;
  logic         SN   = 1'b1;
  logic [1:0]   MODE = MODE_HOLD;
  logic [W-1:0] D    = '0;
  logic         SI   = 1'b0;
  logic [W-1:0] Q, QN;
  logic         SO;
`ifdef DFFRS_PARITY_EN
  logic         PAR;
`endif

  always #5 CK = ~CK;

  dffrs_shift_bank #(.WIDTH(W), .SET_VALUE(SETV)) dut (
    .CK   (CK),
    .RN   (RN),
    .SN   (SN),
    .MODE (MODE),
    .D    (D),
    .SI   (SI),
    .Q    (Q),
    .QN   (QN),
`ifdef DFFRS_PARITY_EN
    .SO   (SO),
    .PAR  (PAR)
`else
    .SO   (SO)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [W-1:0] m_q;
  logic         m_so;
  bit           model_on = 1'b0;

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  always @(negedge CK) begin
    if (model_on) begin
      check("model_q", Q, m_q);
      check("model_qn", QN, ~m_q);
      check("model_so", W'(SO), W'(m_so));
`ifdef DFFRS_PARITY_EN
      check("model_par", W'(PAR), W'(^m_q));
`endif
    end
  end

  // One clocked operation; the model is advanced right after the edge.
  task automatic cyc(input logic [1:0] md, input logic [W-1:0] dd, input logic si);
    MODE = md;
    D    = dd;
    SI   = si;
    @(posedge CK);
    case (md)
      MODE_LOAD: m_q = dd;
      MODE_SHL: begin
        m_so = (m_q >> (W - 1)) % 2 == 1;
        m_q  = (m_q << 1) | W'(si);
      end
      MODE_SHR: begin
        m_so = m_q % 2 == 1;
        m_q  = (m_q >> 1) | (W'(si) << (W - 1));
      end
      default: ;
    endcase
    @(negedge CK);
  endtask

  task automatic pulse_rn();
    #1 RN = 1'b0;
    #1 check("async_rn_q", Q, 8'h00);
    check("async_rn_so", W'(SO), 8'h00);
    m_q  = '0;
    m_so = 1'b0;
    #1 RN = 1'b1;
  endtask

  task automatic pulse_sn();
    #1 SN = 1'b0;
    #1 check("async_sn_q", Q, SETV);
    check("async_sn_so", W'(SO), 8'h00);
    m_q  = SETV;
    m_so = 1'b0;
    #1 SN = 1'b1;
  endtask

  logic [W-1:0] so_exp;

  initial begin
    @(negedge CK);
    // Reset and set with no clock involvement
    #1 RN = 1'b0; SN = 1'b0;
    #1 check("rn_sn_low_q", Q, 8'h00);
    check("rn_sn_low_qn", QN, 8'hFF);
    check("rn_sn_low_so", W'(SO), 8'h00);
    SN = 1'b1;
    #1 check("rn_low_q", Q, 8'h00);
    check("rn_low_qn", QN, 8'hFF);
    #3 check("rn_low_after_edge_q", Q, 8'h00);
    RN = 1'b1;
    #1 SN = 1'b0;
    #1 check("sn_low_q", Q, 8'hFF);
    check("sn_low_qn", QN, 8'h00);
    check("sn_low_so", W'(SO), 8'h00);
    #1 SN = 1'b1;
    m_q = SETV;
    m_so = 1'b0;
    model_on = 1'b1;

    repeat (3) cyc(MODE_HOLD, 8'h00, 1'b1);
    check("hold_q", Q, 8'hFF);

    cyc(MODE_LOAD, 8'hA5, 1'b0);
    check("load_a5", Q, 8'hA5);
    cyc(MODE_SHL, 8'h00, 1'b1);
    check("shl1_q", Q, 8'h4B);
    check("shl1_so", W'(SO), 8'h01);
    cyc(MODE_SHL, 8'h00, 1'b0);
    check("shl2_q", Q, 8'h96);
    check("shl2_so", W'(SO), 8'h00);

    cyc(MODE_LOAD, 8'h81, 1'b0);
    so_exp = 8'b1000_0001;
    for (int i = 0; i < 8; i++) begin
      cyc(MODE_SHR, 8'h00, 1'b0);
      check("shr_so_seq", W'(SO), W'(so_exp[i]));
    end
    check("shr_final_q", Q, 8'h00);

    cyc(MODE_LOAD, 8'h5A, 1'b0);
    cyc(MODE_SHL, 8'h00, 1'b1);
    pulse_rn();
    check("after_rn_qn", QN, 8'hFF);
    cyc(MODE_LOAD, 8'h3C, 1'b0);
    check("reload_3c", Q, 8'h3C);

`ifdef DFFRS_PARITY_EN
    cyc(MODE_LOAD, 8'h07, 1'b0);
    check("par_07", W'(PAR), 8'h01);
    cyc(MODE_LOAD, 8'h03, 1'b0);
    check("par_03", W'(PAR), 8'h00);
    cyc(MODE_LOAD, 8'h01, 1'b0);
    pulse_rn();
    check("par_after_rn", W'(PAR), 8'h00);
`endif

    for (int n = 0; n < 400; n++) begin
      int r;
      r = $urandom_range(0, 39);
      if (r == 0) pulse_rn();
      else if (r == 1) pulse_sn();
      cyc(2'($urandom_range(0, 3)), W'($urandom), 1'($urandom));
    end

    model_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
